// File: rtl/regfile_mp.sv
// Multi-port register file with two write lanes, optional write-to-read bypass,
// optional hardwired-zero register 0 and a per-register busy scoreboard.
module regfile_mp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD     = 2,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   wr_en,
  input  logic [2*ADDR_WIDTH-1:0]      wr_addr,
  input  logic [2*DATA_WIDTH-1:0]      wr_data,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  input  logic                         rsv_en,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr,
  output logic [2**ADDR_WIDTH-1:0]     busy,
  output logic [ADDR_WIDTH:0]          busy_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [Depth-1:0]      busy_q, busy_d;
  logic [ADDR_WIDTH:0]   busy_cnt_q, busy_cnt_d;

  logic [ADDR_WIDTH-1:0] wa0, wa1;
  logic [DATA_WIDTH-1:0] wd0, wd1;

  assign wa0 = wr_addr[0 +: ADDR_WIDTH];
  assign wa1 = wr_addr[ADDR_WIDTH +: ADDR_WIDTH];
  assign wd0 = wr_data[0 +: DATA_WIDTH];
  assign wd1 = wr_data[DATA_WIDTH +: DATA_WIDTH];

  // Storage update: lane 1 is the younger instruction, so it wins on an address clash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < Depth; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < Depth; r++) begin
        if (!(ZERO_REG && r == 0)) begin
          if (wr_en[1] && wa1 == ADDR_WIDTH'(r)) begin
            mem_q[r] <= wd1;
          end else if (wr_en[0] && wa0 == ADDR_WIDTH'(r)) begin
            mem_q[r] <= wd0;
          end
        end
      end
    end
  end

  logic [ADDR_WIDTH-1:0] ra;
  logic [DATA_WIDTH-1:0] rv;

  // Combinational read ports with optional same-cycle bypass (lane 1 checked last to win).
  always_comb begin
    rd_data = '0;
    ra      = '0;
    rv      = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      rv = mem_q[ra];
      // Writes are ignored under reset, so the bypass must not leak them either.
      if (BYPASS && rst_n) begin
        if (wr_en[0] && wa0 == ra) rv = wd0;
        if (wr_en[1] && wa1 == ra) rv = wd1;
      end
      if (ZERO_REG && ra == '0) rv = '0;
      rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rv;
    end
  end

  logic set_r, clr_r;

  // Scoreboard next state: a new reservation beats a same-cycle writeback release.
  always_comb begin
    busy_d     = busy_q;
    busy_cnt_d = '0;
    set_r      = 1'b0;
    clr_r      = 1'b0;
    for (int r = 0; r < Depth; r++) begin
      set_r = rsv_en && (rsv_addr == ADDR_WIDTH'(r));
      clr_r = (wr_en[0] && wa0 == ADDR_WIDTH'(r)) || (wr_en[1] && wa1 == ADDR_WIDTH'(r));
      if (set_r) begin
        busy_d[r] = 1'b1;
      end else if (clr_r) begin
        busy_d[r] = 1'b0;
      end
    end
    if (ZERO_REG) busy_d[0] = 1'b0;
    for (int r = 0; r < Depth; r++) begin
      busy_cnt_d = busy_cnt_d + {{ADDR_WIDTH{1'b0}}, busy_d[r]};
    end
  end

  // Scoreboard and its population count registered together so they always agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: default config (bypass, zero reg) and alternate config (no bypass,
// ordinary reg 0) driven by the same stimulus and checked against hand-computed values.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_alt;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [31:0] busy, busy_alt;
  logic [5:0]  busy_cnt, busy_cnt_alt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  regfile_mp #(
    .ZERO_REG (1'b0),
    .BYPASS   (1'b0)
  ) u_alt (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data_alt),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (busy_alt),
    .busy_cnt (busy_cnt_alt)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rsv;
    logic [4:0]  ra;
    logic [4:0]  rd0;
    logic [4:0]  rd1;
    logic [31:0] e0, e1;      // default config, same cycle
    logic [31:0] ea0, ea1;    // alternate config, same cycle
    logic [31:0] ebusy, eabusy;
    logic [5:0]  ecnt, eacnt;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle();
    wr_en = 2'b00; wr_addr = '0; wr_data = '0; rsv_en = 1'b0; rsv_addr = '0;
  endtask

  initial begin
    //              we    wa0    wd0           wa1    wd1           rsv   ra     rd0    rd1
    //              e0            e1            ea0           ea1
    //              ebusy         eabusy        ecnt  eacnt
    vecs[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6,
                 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 6'd0, 6'd0};
    vecs[1]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd7,
                 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 6'd0, 6'd0};
    vecs[2]  = '{2'b11, 5'd7, 32'h1111, 5'd7, 32'h2222, 1'b0, 5'd0, 5'd7, 5'd5,
                 32'h2222, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 6'd0, 6'd0};
    vecs[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7,
                 32'h2222, 32'h2222, 32'h2222, 32'h2222, 32'h0, 32'h0, 6'd0, 6'd0};
    vecs[4]  = '{2'b10, 5'd0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 6'd0, 6'd1};
    vecs[5]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd3,
                 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h8, 32'h9, 6'd1, 6'd2};
    vecs[6]  = '{2'b10, 5'd0, 32'h0, 5'd3, 32'h33, 1'b1, 5'd3, 5'd3, 5'd5,
                 32'h33, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h8, 32'h9, 6'd1, 6'd2};
    vecs[7]  = '{2'b01, 5'd3, 32'h44, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3,
                 32'h44, 32'h44, 32'h33, 32'h33, 32'h0, 32'h1, 6'd0, 6'd1};
    vecs[8]  = '{2'b11, 5'd12, 32'hA, 5'd13, 32'hB, 1'b1, 5'd10, 5'd12, 5'd13,
                 32'hA, 32'hB, 32'h0, 32'h0, 32'h400, 32'h401, 6'd1, 6'd2};
    vecs[9]  = '{2'b01, 5'd10, 32'hC, 5'd0, 32'h0, 1'b1, 5'd31, 5'd10, 5'd31,
                 32'hC, 32'h0, 32'h0, 32'h0, 32'h80000000, 32'h80000001, 6'd1, 6'd2};
    vecs[10] = '{2'b10, 5'd0, 32'h0, 5'd20, 32'h55, 1'b1, 5'd21, 5'd20, 5'd21,
                 32'h55, 32'h0, 32'h0, 32'h0, 32'h80200000, 32'h80200001, 6'd2, 6'd3};
    vecs[11] = '{2'b11, 5'd31, 32'h1, 5'd21, 32'h2, 1'b0, 5'd0, 5'd31, 5'd21,
                 32'h1, 32'h2, 32'h0, 32'h0, 32'h0, 32'h1, 6'd0, 6'd1};

    // Reset and confirm every register reads zero on both ports.
    rst_n = 1'b0; idle(); rd_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 32; r++) begin
      rd_addr = {5'(r), 5'(r)};
      #1;
      check($sformatf("reset_rd_r%0d", r), rd_data, 64'h0);
      check($sformatf("reset_rd_alt_r%0d", r), rd_data_alt, 64'h0);
    end
    check("reset_busy", {busy_alt, busy}, 64'h0);
    check("reset_cnt", {busy_cnt_alt, busy_cnt}, 64'h0);

    // Table-driven sequence.
    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      wr_en    = vecs[v].we;
      wr_addr  = {vecs[v].wa1, vecs[v].wa0};
      wr_data  = {vecs[v].wd1, vecs[v].wd0};
      rsv_en   = vecs[v].rsv;
      rsv_addr = vecs[v].ra;
      rd_addr  = {vecs[v].rd1, vecs[v].rd0};
      #1;
      check($sformatf("v%0d_rd", v), rd_data, {vecs[v].e1, vecs[v].e0});
      check($sformatf("v%0d_rd_alt", v), rd_data_alt, {vecs[v].ea1, vecs[v].ea0});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_busy", v), busy, 64'(vecs[v].ebusy));
      check($sformatf("v%0d_busy_alt", v), busy_alt, 64'(vecs[v].eabusy));
      check($sformatf("v%0d_cnt", v), busy_cnt, 64'(vecs[v].ecnt));
      check($sformatf("v%0d_cnt_alt", v), busy_cnt_alt, 64'(vecs[v].eacnt));
    end

    // Reserve every register, then reset asynchronously between edges.
    for (int r = 0; r < 32; r++) begin
      @(negedge clk);
      idle();
      rsv_en = 1'b1; rsv_addr = 5'(r);
    end
    @(posedge clk); #1;
    idle();
    check("all_busy", busy, 64'hFFFFFFFE);
    check("all_busy_alt", busy_alt, 64'hFFFFFFFF);
    check("all_cnt", busy_cnt, 64'd31);
    check("all_cnt_alt", busy_cnt_alt, 64'd32);
    rd_addr = {5'd31, 5'd5};
    #2;
    rst_n = 1'b0;
    #1;
    check("async_busy", {busy_alt, busy}, 64'h0);
    check("async_cnt", {busy_cnt_alt, busy_cnt}, 64'h0);
    check("async_rd", rd_data, 64'h0);
    check("async_rd_alt", rd_data_alt, 64'h0);

    // Writes presented during reset must be ignored, also via the bypass.
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h99};
    #1;
    check("inrst_bypass", rd_data, 64'h0);
    @(posedge clk); #1;
    check("inrst_rd", rd_data, 64'h0);
    check("inrst_rd_alt", rd_data_alt, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_bypass", rd_data, 64'h99);
    check("post_rst_alt_old", rd_data_alt, 64'h0);
    @(posedge clk); #1;
    idle();
    #1;
    check("post_rst_rd", rd_data, 64'h99);
    check("post_rst_rd_alt", rd_data_alt, 64'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
